// File: rtl/ir_link_ctrl.sv
// ir_link_ctrl: SIR-style IrDA link controller.
//
// Serialises one byte per transfer into a 10-bit SIR frame (start 0, d0..d7 LSB first, stop 1).
// Each 0 bit is sent as a PULSE_CYC-cycle LED pulse at the start of its BIT_CYC-cycle period.
// The controller keeps off the air while the receiver sees activity. It blanks its own echo
// after sending and puts the transceiver into shutdown after a long idle stretch.
//
// Ports
//   CLK_i       in   clock, rising edge
//   RST_i       in   synchronous active-high reset
//   RXD_i       in   raw transceiver receive line, low = IR pulse, asynchronous
//   tx_valid_i  in   byte offered for transmission
//   tx_data_i   in   [7:0] byte to transmit
//   tx_ready_o  out  byte accepted on a rising edge where tx_valid_i & tx_ready_o
//   TXD_o       out  transceiver LED drive, active-high, registered
//   SD_o        out  transceiver shutdown, active-high
//   rx_pulse_o  out  synchronised RX pulse, blanked outside IDLE/RX_BUSY
//   tx_done_o   out  one-cycle strobe after the last bit period of a frame
//   busy_o      out  state is not IDLE
//
// All timing parameters must be at least 1 and below 2^24.

module ir_link_ctrl #(
   parameter int unsigned BIT_CYC     = 104,
   parameter int unsigned PULSE_CYC   = 20,
   parameter int unsigned QUIET_CYC   = 1040,
   parameter int unsigned RECOVER_CYC = 208,
   parameter int unsigned SLEEP_CYC   = 1200000,
   parameter int unsigned WAKE_CYC    = 1200
) (
   input  logic       CLK_i,
   input  logic       RST_i,
   input  logic       RXD_i,
   input  logic       tx_valid_i,
   input  logic [7:0] tx_data_i,
   output logic       tx_ready_o,
   output logic       TXD_o,
   output logic       SD_o,
   output logic       rx_pulse_o,
   output logic       tx_done_o,
   output logic       busy_o
);

   localparam logic [23:0] BitLast     = 24'(BIT_CYC - 1);
   localparam logic [23:0] PulseLen    = 24'(PULSE_CYC);
   localparam logic [23:0] QuietLoad   = 24'(QUIET_CYC);
   localparam logic [23:0] RecoverLast = 24'(RECOVER_CYC - 1);
   localparam logic [23:0] SleepLast   = 24'(SLEEP_CYC - 1);
   localparam logic [23:0] WakeLast    = 24'(WAKE_CYC - 1);
   localparam logic [3:0]  LastBit     = 4'd9;

   typedef enum logic [2:0] {
      StIdle,
      StRxBusy,
      StTx,
      StRecover,
      StSleep,
      StWake
   } state_e;

   state_e      r_state;
   state_e      w_state_next;

   logic        r_rx_meta;
   logic        r_rx_sync;
   logic [23:0] r_timer;
   logic [3:0]  r_bit_idx;
   logic [9:0]  r_frame;
   logic        r_txd;
   logic        r_tx_done;

   logic        w_rx_s;
   logic        w_tx_ready;
   logic        w_xfer;
   logic        w_idle_quiet;
   logic        w_bit_end;
   logic        w_frame_end;
   logic        w_quiet_end;
   logic        w_recover_end;
   logic        w_sleep_hit;
   logic        w_wake_end;
   logic [3:0]  w_next_idx;
   logic [23:0] w_next_timer;
   logic        w_next_pulse;

   // Receive line is low-active; rx_s is high while an IR pulse is seen.
   assign w_rx_s       = ~r_rx_sync;
   // Ready depends only on state, sync flops and reset, never on tx_valid_i.
   assign w_tx_ready   = (r_state == StIdle) && !w_rx_s && !RST_i;
   assign w_xfer       = w_tx_ready && tx_valid_i;
   assign w_idle_quiet = !tx_valid_i && !w_rx_s;

   assign w_bit_end     = (r_timer == BitLast);
   assign w_frame_end   = w_bit_end && (r_bit_idx == LastBit);
   // Timer holds the remaining silent cycles; leave when the last one has been seen.
   assign w_quiet_end   = (r_timer <= 24'd1);
   assign w_recover_end = (r_timer == RecoverLast);
   assign w_sleep_hit   = (r_timer == SleepLast);
   assign w_wake_end    = (r_timer == WakeLast);

   // Position within the frame for the next TX cycle, used to pre-compute the registered TXD.
   assign w_next_idx   = w_bit_end ? (r_bit_idx + 4'd1) : r_bit_idx;
   assign w_next_timer = w_bit_end ? 24'd0 : (r_timer + 24'd1);
   assign w_next_pulse = !r_frame[w_next_idx] && (w_next_timer < PulseLen);

   // State register
   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; w_xfer already excludes rx_s so RX wins over tx_valid_i.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_rx_s) begin
               w_state_next = StRxBusy;
            end else if (w_xfer) begin
               w_state_next = StTx;
            end else if (w_idle_quiet && w_sleep_hit) begin
               w_state_next = StSleep;
            end
         end
         StRxBusy: begin
            if (!w_rx_s && w_quiet_end) begin
               w_state_next = StIdle;
            end
         end
         StTx: begin
            if (w_frame_end) begin
               w_state_next = StRecover;
            end
         end
         StRecover: begin
            if (w_recover_end) begin
               w_state_next = StIdle;
            end
         end
         StSleep: begin
            if (tx_valid_i) begin
               w_state_next = StWake;
            end
         end
         StWake: begin
            if (w_wake_end) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      tx_ready_o = 1'b0;
      SD_o       = 1'b0;
      rx_pulse_o = 1'b0;
      busy_o     = 1'b1;
      unique case (r_state)
         StIdle: begin
            busy_o     = 1'b0;
            tx_ready_o = w_tx_ready;
            rx_pulse_o = w_rx_s;
         end
         StRxBusy: rx_pulse_o = w_rx_s;
         StSleep:  SD_o       = 1'b1;
         default:  ;
      endcase
   end

   assign TXD_o     = r_txd;
   assign tx_done_o = r_tx_done;

   // Datapath: synchroniser, shared timer, frame position and registered TX outputs.
   // The timer is reused per state and cleared on every state change.
   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_timer   <= 24'd0;
         r_bit_idx <= 4'd0;
         r_frame   <= 10'h3ff;
         r_txd     <= 1'b0;
         r_tx_done <= 1'b0;
      end else begin
         r_rx_meta <= RXD_i;
         r_rx_sync <= r_rx_meta;
         r_txd     <= 1'b0;
         r_tx_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_rx_s) begin
                  r_timer <= QuietLoad;
               end else if (w_xfer) begin
                  r_timer   <= 24'd0;
                  r_bit_idx <= 4'd0;
                  r_frame   <= {1'b1, tx_data_i, 1'b0};
                  // Start bit is always 0, so its pulse begins right away.
                  r_txd     <= (PulseLen != 24'd0);
               end else if (w_idle_quiet) begin
                  r_timer <= w_sleep_hit ? 24'd0 : (r_timer + 24'd1);
               end else begin
                  r_timer <= 24'd0;
               end
            end
            StRxBusy: begin
               if (w_rx_s) begin
                  r_timer <= QuietLoad;
               end else if (w_quiet_end) begin
                  r_timer <= 24'd0;
               end else begin
                  r_timer <= r_timer - 24'd1;
               end
            end
            StTx: begin
               if (w_frame_end) begin
                  r_timer   <= 24'd0;
                  r_tx_done <= 1'b1;
               end else begin
                  r_timer   <= w_next_timer;
                  r_bit_idx <= w_next_idx;
                  r_txd     <= w_next_pulse;
               end
            end
            StRecover: begin
               r_timer <= w_recover_end ? 24'd0 : (r_timer + 24'd1);
            end
            StSleep: begin
               r_timer <= 24'd0;
            end
            StWake: begin
               r_timer <= w_wake_end ? 24'd0 : (r_timer + 24'd1);
            end
            default: r_timer <= 24'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_ir_link_ctrl.sv
// tb_ir_link_ctrl: randomized scoreboard bench for ir_link_ctrl.
// The driver pushes expected TXD pulses and tx_done strobes per accepted byte;
// a negedge monitor pops and compares them and checks blanking/shutdown windows.

module tb_ir_link_ctrl;

   localparam int B = 16;   // BIT_CYC
   localparam int P = 5;    // PULSE_CYC
   localparam int Q = 40;   // QUIET_CYC
   localparam int R = 24;   // RECOVER_CYC
   localparam int S = 300;  // SLEEP_CYC
   localparam int W = 30;   // WAKE_CYC

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       rxd   = 1'b1;
   logic       valid = 1'b0;
   logic [7:0] data  = 8'h00;
   logic       tx_ready, txd, sd, rx_pulse, tx_done, busy;

   ir_link_ctrl #(
      .BIT_CYC    (B),
      .PULSE_CYC  (P),
      .QUIET_CYC  (Q),
      .RECOVER_CYC(R),
      .SLEEP_CYC  (S),
      .WAKE_CYC   (W)
   ) dut (
      .CLK_i     (clk),
      .RST_i     (rst),
      .RXD_i     (rxd),
      .tx_valid_i(valid),
      .tx_data_i (data),
      .tx_ready_o(tx_ready),
      .TXD_o     (txd),
      .SD_o      (sd),
      .rx_pulse_o(rx_pulse),
      .tx_done_o (tx_done),
      .busy_o    (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;   // 0 = TXD pulse, 1 = tx_done strobe
      int cycle;
      int len;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  fails  = 0;

   // Expected windows (inclusive cycle ranges)
   int win_lo = -1, win_hi = -2;   // TX + RECOVER
   int slp_lo = -1, slp_hi = -2;   // SLEEP + WAKE
   int sd_lo  = -1, sd_hi  = -2;   // SD_o high
   bit mon_en  = 1'b0;
   int rxp_cnt = 0;

   function automatic void chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d required %0d at cycle %0d", name, act, req, cyc);
      end
   endfunction

   task automatic finish_tb();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   endtask

   // Monitor
   ev_t ev;
   bit  prev_txd  = 1'b0;
   int  p_start   = 0;
   int  p_len_exp = 0;
   bit  in_blank;

   always @(negedge clk) begin
      if (mon_en) begin
         if (txd && !prev_txd) begin
            if (exp_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_pulse: TXD rose at cycle %0d, none required", cyc);
               p_len_exp = -1;
            end else begin
               ev = exp_q.pop_front();
               chk("pulse_kind", 0, ev.kind);
               chk("pulse_start", cyc, ev.cycle);
               p_len_exp = ev.len;
            end
            p_start = cyc;
         end
         if (!txd && prev_txd) chk("pulse_len", cyc - p_start, p_len_exp);
         if (tx_done) begin
            if (exp_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_done: tx_done at cycle %0d, none required", cyc);
            end else begin
               ev = exp_q.pop_front();
               chk("done_kind", 1, ev.kind);
               chk("done_cycle", cyc, ev.cycle);
            end
         end
         prev_txd = txd;
         if (rx_pulse) rxp_cnt++;
         in_blank = (cyc >= win_lo && cyc <= win_hi) || (cyc >= slp_lo && cyc <= slp_hi);
         if (in_blank) begin
            chk("blank_ready", int'(tx_ready), 0);
            chk("blank_busy", int'(busy), 1);
            chk("blank_rx_pulse", int'(rx_pulse), 0);
         end
         chk("sd", int'(sd), int'(cyc >= sd_lo && cyc <= sd_hi));
      end
   end

   // Wait for acceptance, then push the frame's expected pulses and done strobe.
   // trunc_rel >= 0 means a reset lands at cycle k+trunc_rel and cuts the frame there.
   task automatic accept_and_push(input logic [7:0] d, input int exp_k, input int trunc_rel,
                                  output int k);
      int         n     = 0;
      bit         got   = 1'b0;
      logic [9:0] frame;
      int         trunc;
      int         st;
      k = -1;
      while (!got && n < 2000) begin
         @(negedge clk);
         if (tx_ready) begin
            got = 1'b1;
            k   = cyc + 1;
         end
         n++;
      end
      if (!got) begin
         checks++;
         fails++;
         $display("FAIL accept_timeout: tx_ready_o 0 for 2000 cycles, required 1");
         finish_tb();
      end
      @(posedge clk);
      #1;
      valid = 1'b0;
      data  = 8'($urandom);
      if (exp_k >= 0) chk("accept_cycle", k, exp_k);
      frame = {1'b1, d, 1'b0};
      trunc = (trunc_rel < 0) ? -1 : k + trunc_rel;
      for (int i = 0; i < 10; i++) begin
         if (!frame[i]) begin
            st = k + i * B;
            if (trunc < 0) exp_q.push_back('{0, st, P});
            else if (st <= trunc) exp_q.push_back('{0, st, (trunc - st + 1 < P) ? trunc - st + 1 : P});
         end
      end
      if (trunc < 0) exp_q.push_back('{1, k + 10 * B, 0});
      win_lo = k;
      win_hi = (trunc < 0) ? k + 10 * B + R - 1 : trunc;
   endtask

   // Optionally wiggle RXD during TX (echo blanking), quiet it well before IDLE.
   task automatic tail(input int k, input bit toggle);
      while (cyc < k + 10 * B) begin
         @(posedge clk);
         #1;
         rxd = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      rxd = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] d, input bit toggle, input int exp_k, output int k);
      @(posedge clk);
      #1;
      valid = 1'b1;
      data  = d;
      accept_and_push(d, exp_k, -1, k);
      tail(k, toggle);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   initial begin
      int         k, nk, c0, idle0, wk, v, c;
      logic [7:0] d;

      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", int'(tx_ready), 0);
      chk("rst_txd", int'(txd), 0);
      chk("rst_sd", int'(sd), 0);
      chk("rst_done", int'(tx_done), 0);
      chk("rst_rx_pulse", int'(rx_pulse), 0);
      chk("rst_busy", int'(busy), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", int'(tx_ready), 1);
      mon_en = 1'b1;

      // Directed bytes then random back-to-back frames, some with RX noise.
      send_byte(8'h55, 1'b0, -1, k);
      send_byte(8'h00, 1'b1, k + 10 * B + R + 1, nk);
      k = nk;
      send_byte(8'hFF, 1'b1, k + 10 * B + R + 1, nk);
      k = nk;
      for (int i = 0; i < 8; i++) begin
         send_byte(8'($urandom), 1'(i % 2), k + 10 * B + R + 1, nk);
         k = nk;
      end

      // RX activity: 5 low cycles, tx_valid_i raised on the first synchronised low.
      wait_cyc(k + 10 * B + R + 2);
      rxp_cnt = 0;
      d = 8'($urandom);
      @(posedge clk);
      #1;
      c0  = cyc;
      rxd = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      valid = 1'b1;
      data  = d;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rxd = 1'b1;
      accept_and_push(d, c0 + 8 + Q, -1, k);
      chk("rx_pulse_count", rxp_cnt, 5);
      tail(k, 1'b0);

      // Sleep, RX noise while asleep, wake on tx_valid_i.
      idle0  = k + 10 * B + R;
      wk     = idle0 + S + 10;
      sd_lo  = idle0 + S;
      sd_hi  = wk;
      slp_lo = idle0 + S;
      slp_hi = wk + W;
      while (cyc < wk - 1) begin
         @(posedge clk);
         #1;
         rxd = (cyc >= idle0 + S + 1 && cyc < wk - 3) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      rxd = 1'b1;
      d = 8'($urandom);
      @(posedge clk);
      #1;
      valid = 1'b1;
      data  = d;
      accept_and_push(d, wk + W + 2, -1, k);
      tail(k, 1'b0);

      // Reset during bit 4 of a 0x00 frame.
      wait_cyc(k + 10 * B + R + 2);
      @(posedge clk);
      #1;
      v     = cyc;
      valid = 1'b1;
      data  = 8'h00;
      accept_and_push(8'h00, v + 1, 4 * B + 1, k);
      c = k + 4 * B + 1;
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_txd", int'(txd), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_ready", int'(tx_ready), 1);
      chk("mid_rst_done", int'(tx_done), 0);
      repeat (10 * B + R + 10) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      finish_tb();
   end

   initial begin
      #1000000;
      checks++;
      fails++;
      $display("FAIL watchdog: simulation still running at cycle %0d, limit 100000", cyc);
      finish_tb();
   end

endmodule
